// File: rtl/lfsr_individual_test_top.sv
// -----------------------------------------------------------------------------
// lfsr_individual_test_top
//
// Stand-alone wrapper around a Fibonacci XNOR LFSR core for board and bench
// bring-up. On reset the LFSR state and a compare copy of the seed are loaded
// from i_seed_data. While i_enable is high the LFSR advances once per clock,
// and o_lfsr_done pulses for one cycle each time the state comes back round
// to the loaded seed.
//
// The core (lfsr_xnor_core) is width-parameterised so other projects can
// reuse it; this top fixes the width at 5 bits by default.
//
// Ports (top):
//   i_clk        in   1         system clock, rising edge
//   i_rst        in   1         synchronous reset, active-low
//   i_enable     in   1         1 = advance LFSR this cycle, 0 = hold
//   i_seed_data  in   NUM_BITS  seed, sampled only while i_rst = 0
//   o_lfsr_data  out  NUM_BITS  current LFSR state (registered)
//   o_lfsr_done  out  1         1-cycle pulse: state just returned to seed
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// lfsr_xnor_core
//
// Fibonacci LFSR with XNOR feedback. The feedback bit is the XNOR of every
// tapped state bit and is shifted in at bit 0. Because of the XNOR, all-zeros
// is a legal state; all-ones is the lock-up state (it maps to itself).
//
// Ports:
//   clk        in   1         clock, rising edge
//   rst_n      in   1         synchronous reset, active-low; loads seed
//   enable     in   1         advance one step this cycle
//   seed       in   NUM_BITS  value loaded into state and the compare copy
//   state      out  NUM_BITS  registered LFSR state
//   done       out  1         registered pulse: the last step landed on seed
// -----------------------------------------------------------------------------
module lfsr_xnor_core #(
    parameter int NUM_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_BITS-1:0] seed,
    output logic [NUM_BITS-1:0] state,
    output logic                done
);

    // Maximal-length XNOR tap table, one bit per tapped state position.
    // The top bit (NUM_BITS-1) is always part of the tap set. Widths
    // outside 3..12 have no entry and yield an empty mask.
    function automatic logic [11:0] tap_table(input int n);
        logic [11:0] mask;
        case (n)
            3:       mask = 12'h006;  // bits 2,1
            4:       mask = 12'h00C;  // bits 3,2
            5:       mask = 12'h014;  // bits 4,2   (x^5 + x^3 + 1)
            6:       mask = 12'h030;  // bits 5,4
            7:       mask = 12'h060;  // bits 6,5
            8:       mask = 12'h0B8;  // bits 7,5,4,3
            9:       mask = 12'h110;  // bits 8,4
            10:      mask = 12'h240;  // bits 9,6
            11:      mask = 12'h500;  // bits 10,8
            12:      mask = 12'h829;  // bits 11,5,3,0
            default: mask = 12'h000;
        endcase
        return mask;
    endfunction

    localparam logic [11:0]         TAP_TABLE_ENTRY = tap_table(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAP_MASK        = TAP_TABLE_ENTRY[NUM_BITS-1:0];

    logic [NUM_BITS-1:0] state_reg;
    logic [NUM_BITS-1:0] state_next;
    logic [NUM_BITS-1:0] seed_reg;
    logic [NUM_BITS-1:0] tapped;
    logic                done_reg;
    logic                done_next;
    logic                feedback;

    // Gate each state bit by its tap-mask bit; untapped positions contribute
    // a zero, which leaves the XNOR reduction below unchanged.
    generate
        for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_tap
            assign tapped[gi] = state_reg[gi] & TAP_MASK[gi];
        end
    endgenerate

    // XNOR of all tapped bits. For two taps this is plain a XNOR b; for four
    // taps it is the inverted parity of the four, matching the XNOR table.
    assign feedback = ~^tapped;

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        if (enable) begin
            state_next = {state_reg[NUM_BITS-2:0], feedback};
            // Compare the value about to be loaded, so the registered pulse
            // lines up with the cycle in which state shows the seed again.
            done_next  = (state_next == seed_reg);
        end
    end

    // Reset wins over enable; the seed is captured only during reset so
    // later changes on the seed input are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= seed;
            seed_reg  <= seed;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    assign state = state_reg;
    assign done  = done_reg;

endmodule

module lfsr_individual_test_top #(
    parameter int NUM_BITS = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [NUM_BITS-1:0] i_seed_data,
    output logic [NUM_BITS-1:0] o_lfsr_data,
    output logic                o_lfsr_done
);

    lfsr_xnor_core #(
        .NUM_BITS (NUM_BITS)
    ) u_core (
        .clk    (i_clk),
        .rst_n  (i_rst),
        .enable (i_enable),
        .seed   (i_seed_data),
        .state  (o_lfsr_data),
        .done   (o_lfsr_done)
    );

endmodule

// File: tb/tb_lfsr_individual_test_top.sv
// -----------------------------------------------------------------------------
// Testbench for lfsr_individual_test_top (5-bit XNOR LFSR).
//
// The stimulus process drives one cycle at a time and pushes the expected
// (data, done) pair into a queue. A monitor on the falling edge pops and
// compares against the DUT. The reference model holds the LFSR's position on
// its 31-state orbit as an index; stepping is index arithmetic modulo 31,
// the done flag is "index came back to the seed's index", and the all-ones
// seed is a fixed point.
// -----------------------------------------------------------------------------
module tb_lfsr_individual_test_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] seed;
    logic [4:0] data;
    logic       done;

    always #5 clk = ~clk;

    lfsr_individual_test_top #(
        .NUM_BITS (5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (en),
        .i_seed_data (seed),
        .o_lfsr_data (data),
        .o_lfsr_done (done)
    );

    typedef struct packed {
        logic [4:0] data;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         mon_n = 0;

    // Observation log, filled by the monitor while log_on is set.
    bit         log_on = 1'b0;
    logic [4:0] obs_data[$];
    logic       obs_done[$];

    // Reference model state.
    logic [4:0] orbit[31];
    int         m_idx;
    int         m_seed_idx;
    bit         m_lock;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int idx_of(input logic [4:0] v);
        for (int k = 0; k < 31; k++)
            if (orbit[k] == v) return k;
        return -1;
    endfunction

    // Drive one clock's worth of inputs and record what the DUT must show
    // after that edge.
    task automatic cycle(input logic r, input logic e, input logic [4:0] s);
        exp_t x;
        rst  = r;
        en   = e;
        seed = s;
        @(posedge clk);
        #1;
        x.done = 1'b0;
        if (!r) begin
            m_lock     = (s == 5'h1F);
            m_idx      = m_lock ? 0 : idx_of(s);
            m_seed_idx = m_idx;
        end else if (e) begin
            if (m_lock) begin
                x.done = 1'b1;
            end else begin
                m_idx  = (m_idx + 1) % 31;
                x.done = (m_idx == m_seed_idx);
            end
        end
        x.data = m_lock ? 5'h1F : orbit[m_idx];
        exp_q.push_back(x);
    endtask

    // Let the monitor consume everything pushed so far.
    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mon_n++;
            $display("txn %0d: data=%02h done=%b (model %02h/%b)",
                     mon_n, data, done, e.data, e.done);
            chk("data", int'(data), int'(e.data));
            chk("done", int'(done), int'(e.done));
            if (log_on) begin
                obs_data.push_back(data);
                obs_done.push_back(done);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [4:0] first_vals[7];
        logic [4:0] prev;
        int         ndone;
        int         nchg;
        bit         dup;
        bit         saw_ones;

        // Orbit of the zero seed, built from the feedback rule
        // fb = s[4] XNOR s[2], shifted in at the bottom.
        orbit[0] = 5'h00;
        for (int k = 1; k < 31; k++)
            orbit[k] = {orbit[k-1][3:0], ~(orbit[k-1][4] ^ orbit[k-1][2])};

        first_vals = '{5'h01, 5'h03, 5'h07, 5'h0E, 5'h1C, 5'h19, 5'h12};

        rst  = 1'b0;
        en   = 1'b0;
        seed = 5'h00;

        // Reset with seed 0 for two clocks; enable is ignored.
        cycle(1'b0, 1'b1, 5'h00);
        cycle(1'b0, 1'b1, 5'h00);
        drain();
        chk("reset_data", int'(data), 0);
        chk("reset_done", int'(done), 0);

        // Free-run for 110 steps from seed 0.
        log_on = 1'b1;
        obs_data.delete();
        obs_done.delete();
        for (int i = 0; i < 110; i++)
            cycle(1'b1, 1'b1, 5'($urandom_range(0, 31)));
        drain();
        log_on = 1'b0;
        chk("period_log_len", obs_data.size(), 110);
        if (obs_data.size() == 110) begin
            for (int i = 0; i < 7; i++)
                chk($sformatf("step_%0d", i + 1), int'(obs_data[i]), int'(first_vals[i]));
            ndone = 0;
            saw_ones = 1'b0;
            for (int i = 0; i < 110; i++) begin
                if (obs_done[i]) begin
                    ndone++;
                    chk($sformatf("done_at_step_%0d", i + 1),
                        ((i + 1) % 31 == 0) ? 1 : 0, 1);
                    chk($sformatf("done_data_step_%0d", i + 1), int'(obs_data[i]), 0);
                end
                if (obs_data[i] == 5'h1F) saw_ones = 1'b1;
            end
            chk("period_done_count", ndone, 3);
            chk("no_lockup_state", int'(saw_ones), 0);
            dup = 1'b0;
            for (int i = 0; i < 31; i++)
                for (int j = i + 1; j < 31; j++)
                    if (obs_data[i] == obs_data[j]) dup = 1'b1;
            chk("states_distinct", int'(dup), 0);
        end

        // Hold for 10 cycles, then resume.
        prev = data;
        log_on = 1'b1;
        obs_data.delete();
        obs_done.delete();
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b0, 5'($urandom_range(0, 31)));
        drain();
        log_on = 1'b0;
        ndone = 0;
        nchg  = 0;
        foreach (obs_data[i]) begin
            if (obs_data[i] != prev) nchg++;
            if (obs_done[i]) ndone++;
        end
        chk("hold_changes", nchg, 0);
        chk("hold_done", ndone, 0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1, 5'h00);

        // Toggle enable every cycle for 15 cycles: 8 enabled edges.
        drain();
        prev = data;
        log_on = 1'b1;
        obs_data.delete();
        obs_done.delete();
        for (int i = 0; i < 15; i++)
            cycle(1'b1, (i % 2 == 0), 5'($urandom_range(0, 31)));
        drain();
        log_on = 1'b0;
        nchg = 0;
        foreach (obs_data[i]) begin
            if (obs_data[i] != prev) nchg++;
            prev = obs_data[i];
        end
        chk("toggle_steps", nchg, 8);

        // Reset mid-sequence with enable high and a nonzero seed.
        cycle(1'b1, 1'b1, 5'h00);
        cycle(1'b0, 1'b1, 5'h15);
        drain();
        chk("midreset_data", int'(data), 5'h15);
        chk("midreset_done", int'(done), 0);
        log_on = 1'b1;
        obs_data.delete();
        obs_done.delete();
        for (int i = 0; i < 31; i++)
            cycle(1'b1, 1'b1, 5'($urandom_range(0, 31)));
        drain();
        log_on = 1'b0;
        ndone = 0;
        foreach (obs_done[i]) if (obs_done[i]) ndone++;
        chk("seed15_done_count", ndone, 1);
        chk("seed15_return_data", int'(data), 5'h15);
        chk("seed15_return_done", int'(done), 1);

        // Lock-up seed: stays at all-ones, done on every enabled cycle.
        cycle(1'b0, 1'b0, 5'h1F);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1, 5'h00);
        drain();
        chk("lockup_data", int'(data), 5'h1F);
        chk("lockup_done", int'(done), 1);

        // Randomised run with occasional resets and random seeds.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 15) == 0)
                cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            else
                cycle(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        drain();
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
